// File: rtl/riscv_div_pkg.sv
// ============================================================================
// Module   : riscv_div_pkg
// Brief    : Shared types and constants for the RV32M restoring divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

package riscv_div_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } div_state_t;

  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

  // Two's-complement magnitude, applied only when the operation is signed.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_divider_div_step.sv
// ============================================================================
// Module   : div_step
// Brief    : One restoring-division iteration: 33-bit trial subtract.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            msb_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] next_rem_o,
  output logic            q_bit_o
);

  logic [XLEN:0] trial;

  assign trial   = {rem_i, msb_i} - {1'b0, div_i};
  assign q_bit_o = ~trial[XLEN];
  // On borrow the shifted remainder is below the divisor, so it fits in XLEN bits.
  assign next_rem_o = trial[XLEN] ? {rem_i[XLEN-2:0], msb_i} : trial[XLEN-1:0];

endmodule

`default_nettype wire

// File: rtl/riscv_divider.sv
// ============================================================================
// Module   : riscv_divider
// Brief    : Fixed-latency (33 cycle) RV32M DIV/DIVU/REM/REMU restoring divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

module riscv_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  import riscv_div_pkg::*;

  div_state_t      state_q, state_d;
  div_op_t         op_q, op_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] bmag_q, bmag_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic            qsign_q, qsign_d;
  logic            rsign_q, rsign_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;

  logic            load_en, calc_en, fix_en;
  logic            is_signed, sa, sb;
  logic [XLEN-1:0] step_rem, fix_val;
  logic            step_bit;

  assign is_signed = ~op[0];
  assign sa        = is_signed & a[XLEN-1];
  assign sb        = is_signed & b[XLEN-1];

  div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i      (rem_q),
    .msb_i      (quo_q[XLEN-1]),
    .div_i      (bmag_q),
    .next_rem_o (step_rem),
    .q_bit_o    (step_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == 5'd0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy    = (state_q != IDLE);
    load_en = (state_q == IDLE) && start;
    calc_en = (state_q == CALC);
    fix_en  = (state_q == FIX);
  end

  // Special cases override the arithmetic path; latency is unaffected.
  always_comb begin
    fix_val = '0;
    if (div0_q) begin
      fix_val = op_q[1] ? a_q : ALL_ONES;
    end else if (ovf_q) begin
      fix_val = op_q[1] ? '0 : INT_MIN;
    end else begin
      unique case (op_q)
        DIV:     fix_val = qsign_q ? (~quo_q + 1'b1) : quo_q;
        DIVU:    fix_val = quo_q;
        REM:     fix_val = rsign_q ? (~rem_q + 1'b1) : rem_q;
        REMU:    fix_val = rem_q;
        default: fix_val = '0;
      endcase
    end
  end

  always_comb begin
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    bmag_d   = bmag_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    done_d   = fix_en;
    if (load_en) begin
      op_d    = div_op_t'(op);
      cnt_d   = 5'd31;
      a_d     = a;
      bmag_d  = abs_val(b, is_signed);
      rem_d   = '0;
      quo_d   = abs_val(a, is_signed);
      qsign_d = sa ^ sb;
      rsign_d = sa;
      div0_d  = (b == '0);
      ovf_d   = is_signed && (a == INT_MIN) && (b == ALL_ONES);
    end else if (calc_en) begin
      rem_d = step_rem;
      quo_d = {quo_q[XLEN-2:0], step_bit};
      cnt_d = cnt_q - 5'd1;
    end
    if (fix_en) result_d = fix_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= DIV;
      cnt_q    <= '0;
      a_q      <= '0;
      bmag_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      bmag_q   <= bmag_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

`default_nettype wire

// File: doc/riscv_divider.md
# riscv_divider

Multi-cycle 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions in the execute stage. It is the subtractive counterpart of the core's carry-lookahead adder and uses restoring division, one quotient bit per cycle. A start/done handshake lets the pipeline stall on `busy`. The latency is fixed, including for the architectural special cases.

## Interface
Parameters:
- `XLEN`, 32: operand and result width. Only 32 is supported.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a division; sampled only when `busy`=0.
- `op` in 2: operation, captured with `start`; 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `a` in 32: dividend, captured with `start`.
- `b` in 32: divisor, captured with `start`.
- `busy` out 1: high while an operation is in flight.
- `done` out 1: one-cycle pulse marking `result` valid.
- `result` out 32: quotient or remainder; held until the next `done`.

## Operation
- State machine: IDLE, CALC, FIX.
  - IDLE, `start`=1 → CALC. On entry:
    - latch `op`;
    - latch the magnitudes of `a` and `b` (two's-complement negate when the op is signed and bit 31=1);
    - latch sign flags: quotient sign = sa^sb, remainder sign = sa;
    - latch special flags: `b`==0 → div0; `a`==0x80000000 and `b`==0xFFFFFFFF with signed op → ovf;
    - set counter=31, partial remainder=0, quotient register = |a|.
  - CALC, each cycle:
    - trial = {rem[31:0], q[31]} − {1'b0, |b|}, 33-bit;
    - if no borrow (trial[32]=0): rem ← trial, shift q left inserting 1;
    - else: rem ← {rem[31:0], q[31]}, shift q left inserting 0;
    - counter decrements; counter==0 → FIX.
  - FIX, one cycle: select and sign-fix the result, write `result`, pulse `done`, go to IDLE.
- Result selection:
  - div0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → `a`.
  - ovf: DIV → 0x80000000; REM → 0.
  - otherwise: DIV → q negated if the quotient sign is set; DIVU → q; REM → rem negated if the remainder sign is set; REMU → rem.
- Boundary conditions:
  - `start` while `busy`=1: ignored; captured operands are unaffected.
  - `start` in the `done` cycle (state is IDLE): accepted, giving back-to-back operation.
  - `rst` mid-operation: the next edge forces IDLE. The in-flight op is discarded and no `done` is produced.
  - Special cases still run the full 32 CALC cycles, so latency is constant.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, state IDLE, counter 0.
- `start` sampled at edge k:
  - `busy`=1 from k+1 to k+33 (33 cycles);
  - CALC iterations at edges k+1..k+32;
  - FIX at edge k+33, after which `result` is valid and `done`=1 for exactly one cycle (k+33 to k+34), with `busy`=0.
- Latency from the accepting edge to `done`: 33 cycles. Minimum issue interval: 33 cycles.
- `result` changes only at the FIX edge or on reset.

## Structure
- Package `riscv_div_pkg` holds:
  - `XLEN`;
  - `div_op_t` enum: DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11;
  - `div_state_t` enum: IDLE, CALC, FIX;
  - constants `INT_MIN`=32'h80000000 and `ALL_ONES`=32'hFFFFFFFF.
- One natural sub-module, `div_step`: a combinational 33-bit trial subtract returning {next_rem, q_bit}. It is instantiated once, inside CALC.
- The top level holds the FSM, counter, operand, sign and special-flag registers, and the FIX mux.

## Test plan
- DIVU a=100, b=7 → `result`=14, `done` exactly 33 cycles after `start`; REMU, same operands → 2.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD (−3); REM → 0xFFFFFFFF (−1); REMU, same operands → 1.
- Divide by zero, a=5, b=0: DIV and DIVU → 0xFFFFFFFF; REM and REMU → 5; latency still 33.
- Overflow, a=0x80000000, b=0xFFFFFFFF: DIV → 0x80000000, REM → 0. DIVU with the same operands → 0, REMU → 0x80000000.
- Handshake:
  - `start` pulsed at cycle 5 of an op with different operands → ignored, first result correct.
  - New `start` in the `done` cycle → second `done` 33 cycles later.
- `rst` at cycle 10 of an op → `busy`=0 and `result`=0 next cycle, no `done` for that op. A subsequent DIVU 9/3 → 3.
